// File: rtl/alu_dispatch_pkg.sv
// Shared FSM state type and configuration defaults for the ALU dispatch unit.
package alu_dispatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEFAULT_FUN_W          = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int TIMER_W                = 8;

endpackage

// File: rtl/alu_fun_onehot.sv
// Combinational decode of an ALU function code into a one-hot unit select.
module alu_fun_onehot
  import alu_dispatch_pkg::*;
#(
  parameter int FUN_W = DEFAULT_FUN_W
) (
  input  logic [FUN_W-1:0]        fun_i,
  output logic [(1<<FUN_W)-1:0]   onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[fun_i] = 1'b1;
  end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Dispatches one ALU request at a time to a one-hot selected execution unit.
// Define ALU_DISPATCH_TIMEOUT_EN to build in the hung-operation watchdog.
module alu_dispatch_unit
  import alu_dispatch_pkg::*;
#(
  parameter int                    FUN_W          = DEFAULT_FUN_W,
  parameter logic [(1<<FUN_W)-1:0] UNIT_MASK      = '1,
  parameter int                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [FUN_W-1:0]        ALU_FUN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [(1<<FUN_W)-1:0]   UNIT_DONE,
  output logic [(1<<FUN_W)-1:0]   UNIT_ENABLE,
  output logic [FUN_W-1:0]        ACTIVE_FUN,
  output logic                    DONE,
  output logic                    ILLEGAL,
  output logic                    TIMEOUT
);

  localparam int N_UNITS = 1 << FUN_W;

  state_e             state_q, state_d;
  logic [N_UNITS-1:0] enable_q, enable_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic [N_UNITS-1:0] fun_onehot;

  alu_fun_onehot #(
    .FUN_W    (FUN_W)
  ) u_onehot (
    .fun_i    (ALU_FUN),
    .onehot_o (fun_onehot)
  );

`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_q, timeout_d;
`endif

  // A matching done takes priority over the watchdog in the same cycle.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    fun_d     = fun_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          if (UNIT_MASK[ALU_FUN]) begin
            state_d  = BUSY;
            enable_d = fun_onehot;
            fun_d    = ALU_FUN;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            timer_d  = '0;
`endif
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (UNIT_DONE[fun_q]) begin
          state_d  = IDLE;
          enable_d = '0;
          done_d   = 1'b1;
        end
`ifdef ALU_DISPATCH_TIMEOUT_EN
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES)) begin
          state_d   = IDLE;
          enable_d  = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      fun_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      fun_q     <= fun_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_DISPATCH_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  logic [TIMER_W-1:0] timeout_cycles_unused;
  assign timeout_cycles_unused = TIMER_W'(TIMEOUT_CYCLES);
  assign TIMEOUT = 1'b0;
`endif

  assign IN_READY    = (state_q == IDLE);
  assign UNIT_ENABLE = enable_q;
  assign ACTIVE_FUN  = fun_q;
  assign DONE        = done_q;
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Self-checking bench for alu_dispatch_unit; watchdog checks follow ALU_DISPATCH_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_alu_dispatch_unit;

  localparam int         TO_CYCLES = 4;
  localparam logic [3:0] MASK0     = 4'b0111;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rstN;

  logic       valid0;
  logic [1:0] fun0;
  logic       ready0;
  logic [3:0] udone0;
  logic [3:0] en0;
  logic [1:0] act0;
  logic       done0, ill0, to0;

  logic       valid1;
  logic [2:0] fun1;
  logic       ready1;
  logic [7:0] udone1;
  logic [7:0] en1;
  logic [2:0] act1;
  logic       done1, ill1, to1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit v;
    int f;
    int ud;
    int eReady;
    int eEn;
    int eAct;
    int eDone;
    int eIll;
  } vec_t;

  vec_t vecQ[$];

  // Model of the FUN_W=2 instance: in-flight op, its code and cycles spent enabled.
  bit mBusy;
  int mFun;
  int mAge;
  bit mDone, mIll, mTo;

  alu_dispatch_unit #(
    .FUN_W          (2),
    .UNIT_MASK      (MASK0),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut0 (
    .CLK         (clock),
    .RST         (rstN),
    .ALU_FUN     (fun0),
    .IN_VALID    (valid0),
    .IN_READY    (ready0),
    .UNIT_DONE   (udone0),
    .UNIT_ENABLE (en0),
    .ACTIVE_FUN  (act0),
    .DONE        (done0),
    .ILLEGAL     (ill0),
    .TIMEOUT     (to0)
  );

  alu_dispatch_unit #(
    .FUN_W (3)
  ) dut1 (
    .CLK         (clock),
    .RST         (rstN),
    .ALU_FUN     (fun1),
    .IN_VALID    (valid1),
    .IN_READY    (ready1),
    .UNIT_DONE   (udone1),
    .UNIT_ENABLE (en1),
    .ACTIVE_FUN  (act1),
    .DONE        (done1),
    .ILLEGAL     (ill1),
    .TIMEOUT     (to1)
  );

  always #5 clock = ~clock;

  // Hard stop so a stuck run still terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int f, input int ud);
    valid0 = v;
    fun0   = 2'(f);
    udone0 = 4'(ud);
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input bit v, input int f, input int ud, input int r,
                        input int en, input int act, input int d, input int il);
    vec_t x;
    x.v = v; x.f = f; x.ud = ud;
    x.eReady = r; x.eEn = en; x.eAct = act; x.eDone = d; x.eIll = il;
    vecQ.push_back(x);
  endtask

  task automatic modelEdge(input bit v, input int f, input logic [3:0] ud);
    mDone = 0; mIll = 0; mTo = 0;
    if (mBusy) begin
      mAge++;
      if (ud[mFun]) begin
        mBusy = 0;
        mDone = 1;
      end else if (TO_EN && mAge > TO_CYCLES) begin
        mBusy = 0;
        mTo   = 1;
      end
    end else if (v) begin
      if (MASK0[f]) begin
        mBusy = 1;
        mFun  = f;
        mAge  = 0;
      end else begin
        mIll = 1;
      end
    end
  endtask

  initial begin
    int highCycles;
    bit seenTo;
    bit spurious;
    int code;
    int v, f, ud;

    rstN   = 1'b0;
    valid1 = 1'b0;
    fun1   = '0;
    udone1 = '0;
    applyStimulus(0, 0, 0);

    // Reset state.
    #12;
    checkOutput("rst_ready", ready0, 1);
    checkOutput("rst_enable", en0, 0);
    checkOutput("rst_active", act0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_illegal", ill0, 0);
    checkOutput("rst_timeout", to0, 0);
    checkOutput("rst_ready1", ready1, 1);
    checkOutput("rst_enable1", en1, 0);
    rstN = 1'b1;
    stepClock();

    //     v f  ud   rdy en act dn il
    addVec(0, 0, 'h0, 1, 'h0, 0, 0, 0);
    addVec(1, 2, 'h0, 0, 'h4, 2, 0, 0);
    addVec(0, 0, 'h0, 0, 'h4, 2, 0, 0);
    addVec(0, 0, 'h0, 0, 'h4, 2, 0, 0);
    addVec(0, 0, 'h4, 1, 'h0, 2, 1, 0);
    addVec(0, 0, 'h0, 1, 'h0, 2, 0, 0);
    addVec(1, 3, 'h0, 1, 'h0, 2, 0, 1);
    addVec(0, 0, 'h0, 1, 'h0, 2, 0, 0);
    addVec(0, 0, 'hF, 1, 'h0, 2, 0, 0);
    addVec(1, 1, 'h2, 0, 'h2, 1, 0, 0);
    addVec(0, 0, 'h8, 0, 'h2, 1, 0, 0);
    addVec(0, 0, 'hD, 0, 'h2, 1, 0, 0);
    addVec(0, 0, 'h2, 1, 'h0, 1, 1, 0);
    addVec(1, 0, 'h0, 0, 'h1, 0, 0, 0);
    addVec(1, 2, 'h1, 1, 'h0, 0, 1, 0);
    addVec(1, 2, 'h0, 0, 'h4, 2, 0, 0);
    addVec(0, 0, 'h4, 1, 'h0, 2, 1, 0);
    addVec(0, 0, 'h0, 1, 'h0, 2, 0, 0);

    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].v, vecQ[i].f, vecQ[i].ud);
      stepClock();
      checkOutput($sformatf("vec%0d_ready", i), ready0, vecQ[i].eReady);
      checkOutput($sformatf("vec%0d_enable", i), en0, vecQ[i].eEn);
      checkOutput($sformatf("vec%0d_active", i), act0, vecQ[i].eAct);
      checkOutput($sformatf("vec%0d_done", i), done0, vecQ[i].eDone);
      checkOutput($sformatf("vec%0d_illegal", i), ill0, vecQ[i].eIll);
      checkOutput($sformatf("vec%0d_timeout", i), to0, 0);
    end

    // Hung operation: watchdog abort, or persistence when the watchdog is absent.
    applyStimulus(1, 1, 0);
    stepClock();
    applyStimulus(0, 0, 0);
`ifdef ALU_DISPATCH_TIMEOUT_EN
    highCycles = 0;
    seenTo     = 0;
    for (int i = 0; i < 40 && !seenTo; i++) begin
      if (en0 == 4'b0010) highCycles++;
      stepClock();
      if (to0) seenTo = 1;
    end
    checkOutput("wd_timeout_seen", seenTo, 1);
    checkOutput("wd_enable_cycles", highCycles, TO_CYCLES + 1);
    checkOutput("wd_enable_drop", en0, 0);
    checkOutput("wd_ready", ready0, 1);
    checkOutput("wd_no_done", done0, 0);
    stepClock();
    checkOutput("wd_timeout_one_cycle", to0, 0);
`else
    seenTo = 0;
    for (int i = 0; i < 30; i++) begin
      stepClock();
      if (to0) seenTo = 1;
    end
    checkOutput("nowd_no_timeout", seenTo, 0);
    checkOutput("nowd_enable_held", en0, 4'b0010);
    checkOutput("nowd_busy", ready0, 0);
    applyStimulus(0, 0, 4'b0010);
    stepClock();
    checkOutput("nowd_done", done0, 1);
    checkOutput("nowd_enable_drop", en0, 0);
    applyStimulus(0, 0, 0);
    stepClock();
`endif

    // Done arriving in the last cycle before the watchdog would fire.
    applyStimulus(1, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0);
    for (int i = 0; i < TO_CYCLES; i++) stepClock();
    checkOutput("race_enable_before", en0, 4'b0001);
    applyStimulus(0, 0, 4'b0001);
    stepClock();
    checkOutput("race_done", done0, 1);
    checkOutput("race_timeout", to0, 0);
    checkOutput("race_enable", en0, 0);
    applyStimulus(0, 0, 0);
    stepClock();
    checkOutput("race_done_after", done0, 0);
    checkOutput("race_timeout_after", to0, 0);

    // Reset in the middle of an operation.
    applyStimulus(1, 2, 0);
    stepClock();
    applyStimulus(0, 0, 0);
    checkOutput("midrst_busy", en0, 4'b0100);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_enable", en0, 0);
    checkOutput("midrst_active", act0, 0);
    checkOutput("midrst_done", done0, 0);
    checkOutput("midrst_illegal", ill0, 0);
    checkOutput("midrst_timeout", to0, 0);
    checkOutput("midrst_ready", ready0, 1);
    #2;
    rstN = 1'b1;
    applyStimulus(0, 0, 4'b0100);
    spurious = 0;
    stepClock();
    checkOutput("postrst_ready", ready0, 1);
    for (int i = 0; i < 8; i++) begin
      if (done0 || to0) spurious = 1;
      stepClock();
    end
    checkOutput("postrst_no_pulse", spurious, 0);
    applyStimulus(0, 0, 0);

    // FUN_W=3 back-to-back with IN_VALID held high.
    valid1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      code   = $urandom_range(0, 7);
      fun1   = 3'(code);
      udone1 = '0;
      stepClock();
      checkOutput($sformatf("b2b%0d_enable", k), en1, 1 << code);
      checkOutput($sformatf("b2b%0d_active", k), act1, code);
      checkOutput($sformatf("b2b%0d_busy", k), ready1, 0);
      checkOutput($sformatf("b2b%0d_onehot", k), $countones(en1), 1);
      fun1   = 3'($urandom_range(0, 7));
      udone1 = 8'(1 << code);
      stepClock();
      checkOutput($sformatf("b2b%0d_done", k), done1, 1);
      checkOutput($sformatf("b2b%0d_ready", k), ready1, 1);
      checkOutput($sformatf("b2b%0d_idle_enable", k), en1, 0);
    end
    valid1 = 1'b0;
    udone1 = '0;

    // Random traffic on the FUN_W=2 instance against the model.
    rstN = 1'b0;
    #4;
    rstN  = 1'b1;
    mBusy = 0; mFun = 0; mAge = 0;
    for (int n = 0; n < 400; n++) begin
      v  = $urandom_range(0, 1);
      f  = $urandom_range(0, 3);
      ud = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : 0;
      applyStimulus(v[0], f, ud);
      modelEdge(v[0], f, 4'(ud));
      stepClock();
      checkOutput($sformatf("rnd%0d_ready", n), ready0, !mBusy);
      checkOutput($sformatf("rnd%0d_enable", n), en0, mBusy ? (1 << mFun) : 0);
      checkOutput($sformatf("rnd%0d_active", n), act0, mFun);
      checkOutput($sformatf("rnd%0d_done", n), done0, mDone);
      checkOutput($sformatf("rnd%0d_illegal", n), ill0, mIll);
      checkOutput($sformatf("rnd%0d_timeout", n), to0, mTo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
